pc_flow_ctrl: RTL and testbench

//  Control front-end for the PC register: combines stall, branch/jump and trap requests into one

---
 rtl/pc_flow_ctrl.sv | 155 +++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - PC redirect arbiter: stall/jump/trap merge, pending-jump capture, flush window
// Optional debug halt support is compiled in with PC_FLOW_CTRL_DBG_HALT_EN.
module pc_flow_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_req_i,
    input  logic              ex_jump_req_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
`ifdef PC_FLOW_CTRL_DBG_HALT_EN
    input  logic              dbg_halt_req_i,
    output logic              dbg_halted_o,
`endif
    output logic              hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              flush_o,
    output logic              trap_ack_o
);

    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("pc_flow_ctrl: FLUSH_CYCLES must be 0..7");
    end

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;

    logic              dbg_halt_req;
    logic              halted;
    logic              hold;
    logic              jump;
    logic [ADDR_W-1:0] jaddr;
    logic              flush;
    logic              ack;

`ifdef PC_FLOW_CTRL_DBG_HALT_EN
    assign dbg_halt_req = dbg_halt_req_i;
    assign dbg_halted_o = rst_n & halted;
`else
    assign dbg_halt_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        flush_cnt_d = flush_cnt_q;
        jump        = 1'b0;
        jaddr       = '0;
        flush       = 1'b0;
        ack         = 1'b0;
        halted      = (state_q == ST_HALT);
        hold        = stall_req_i | halted;

        case (state_q)
            ST_RUN: begin
                if (!stall_req_i) begin
                    if (trap_req_i) begin
                        jump  = 1'b1;
                        jaddr = trap_addr_i;
                        ack   = 1'b1;
                    end else if (pend_vld_q) begin
                        jump  = 1'b1;
                        jaddr = pend_addr_q;
                    end else if (ex_jump_req_i) begin
                        jump  = 1'b1;
                        jaddr = ex_jump_addr_i;
                    end
                end
                if (jump) begin
                    flush       = 1'b1;
                    pend_vld_d  = 1'b0;
                    flush_cnt_d = FLUSH_LD;
                    state_d     = (FLUSH_LD == 3'd0) ? ST_RUN : ST_FLUSH;
                end else begin
                    // A jump arriving while held is the oldest redirect; anything after it is wrong-path.
                    if (stall_req_i && ex_jump_req_i && !pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = ex_jump_addr_i;
                    end
                    if (dbg_halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_FLUSH: begin
                flush = 1'b1;
                if (!stall_req_i) begin
                    if (trap_req_i) begin
                        jump        = 1'b1;
                        jaddr       = trap_addr_i;
                        ack         = 1'b1;
                        flush_cnt_d = FLUSH_LD;
                    end else if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end

            ST_HALT: begin
                if (ex_jump_req_i && !pend_vld_q) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = ex_jump_addr_i;
                end
                if (!dbg_halt_req) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low during reset so the PC register sees no stray hold or jump.
    assign hold_flag_o = rst_n & hold;
    assign jump_flag_o = rst_n & jump;
    assign jump_addr_o = (rst_n && jump) ? jaddr : '0;
    assign flush_o     = rst_n & flush;
    assign trap_ack_o  = rst_n & ack;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - directed vector bench for pc_flow_ctrl
module tb_pc_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_req_i;
    logic        ex_jump_req_i;
    logic [31:0] ex_jump_addr_i;
    logic        trap_req_i;
    logic [31:0] trap_addr_i;
    logic        hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        flush_o;
    logic        trap_ack_o;
`ifdef PC_FLOW_CTRL_DBG_HALT_EN
    logic        dbg_halt_req_i;
    logic        dbg_halted_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_flow_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_req_i    (stall_req_i),
        .ex_jump_req_i  (ex_jump_req_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .trap_req_i     (trap_req_i),
        .trap_addr_i    (trap_addr_i),
`ifdef PC_FLOW_CTRL_DBG_HALT_EN
        .dbg_halt_req_i (dbg_halt_req_i),
        .dbg_halted_o   (dbg_halted_o),
`endif
        .hold_flag_o    (hold_flag_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .flush_o        (flush_o),
        .trap_ack_o     (trap_ack_o)
    );

    typedef struct {
        logic        st;
        logic        ej;
        logic [31:0] ea;
        logic        tr;
        logic [31:0] ta;
        logic        h;
        logic        jf;
        logic [31:0] ja;
        logic        fl;
        logic        ak;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic ej, input logic [31:0] ea,
                       input logic tr, input logic [31:0] ta,
                       input logic h, input logic jf, input logic [31:0] ja,
                       input logic fl, input logic ak);
        vec_t v;
        v.st = st; v.ej = ej; v.ea = ea; v.tr = tr; v.ta = ta;
        v.h = h; v.jf = jf; v.ja = ja; v.fl = fl; v.ak = ak;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ej, input logic [31:0] ea,
                         input logic tr, input logic [31:0] ta);
        stall_req_i    = st;
        ex_jump_req_i  = ej;
        ex_jump_addr_i = ea;
        trap_req_i     = tr;
        trap_addr_i    = ta;
    endtask

    task automatic chk_out(input string tag, input logic h, input logic jf,
                           input logic [31:0] ja, input logic fl, input logic ak);
        chk({tag, ".hold"},  32'(hold_flag_o), 32'(h));
        chk({tag, ".jump"},  32'(jump_flag_o), 32'(jf));
        chk({tag, ".addr"},  jump_addr_o,      ja);
        chk({tag, ".flush"}, 32'(flush_o),     32'(fl));
        chk({tag, ".ack"},   32'(trap_ack_o),  32'(ak));
    endtask

    initial begin
        // st ej ea          tr ta           | h  jf ja           fl ak
        // single EX jump, three flush cycles
        add(0, 1, 32'h100,   0, 0,            0, 1, 32'h100,     1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // jump captured while stalled, issued when stall drops
        add(1, 0, 0,         0, 0,            1, 0, 0,           0, 0);
        add(1, 1, 32'h200,   0, 0,            1, 0, 0,           0, 0);
        add(1, 0, 0,         0, 0,            1, 0, 0,           0, 0);
        add(1, 0, 0,         0, 0,            1, 0, 0,           0, 0);
        add(0, 0, 0,         0, 0,            0, 1, 32'h200,     1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // trap beats simultaneous EX jump
        add(0, 1, 32'h300,   1, 32'h8000_0000, 0, 1, 32'h8000_0000, 1, 1);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // wrong-path jump ignored in flush, stalls stretch the window
        add(0, 1, 32'h600,   0, 0,            0, 1, 32'h600,     1, 0);
        add(0, 1, 32'h400,   0, 0,            0, 0, 0,           1, 0);
        add(1, 0, 0,         0, 0,            1, 0, 0,           1, 0);
        add(1, 0, 0,         0, 0,            1, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // pending jump beats younger captures and a live jump
        add(1, 1, 32'h700,   0, 0,            1, 0, 0,           0, 0);
        add(1, 1, 32'h800,   0, 0,            1, 0, 0,           0, 0);
        add(0, 1, 32'h900,   0, 0,            0, 1, 32'h700,     1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // trap inside flush: waits for stall, then reloads the window
        add(0, 1, 32'hA00,   0, 0,            0, 1, 32'hA00,     1, 0);
        add(1, 0, 0,         1, 32'hC00,      1, 0, 0,           1, 0);
        add(0, 0, 0,         1, 32'hC00,      0, 1, 32'hC00,     1, 1);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);
        // trap discards a pending jump
        add(1, 1, 32'hB00,   0, 0,            1, 0, 0,           0, 0);
        add(1, 0, 0,         1, 32'hD00,      1, 0, 0,           0, 0);
        add(0, 0, 0,         1, 32'hD00,      0, 1, 32'hD00,     1, 1);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           1, 0);
        add(0, 0, 0,         0, 0,            0, 0, 0,           0, 0);

`ifdef PC_FLOW_CTRL_DBG_HALT_EN
        dbg_halt_req_i = 1'b0;
`endif
        rst_n = 1'b0;
        drive(1, 1, 32'h123, 1, 32'h456);
        #12;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].ej, vecs[i].ea, vecs[i].tr, vecs[i].ta);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].h, vecs[i].jf, vecs[i].ja, vecs[i].fl, vecs[i].ak);
        end

        // async reset with a pending jump: the jump must be dropped
        @(negedge clk);
        drive(1, 1, 32'hE00, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_pend", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        chk_out("rst_pend_after", 0, 0, 0, 0, 0);

        // async reset mid-flush: flush ends immediately
        @(negedge clk);
        drive(0, 1, 32'hF00, 0, 0);
        #1;
        chk_out("rst_fl_issue", 0, 1, 32'hF00, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("rst_fl_mid.flush", 32'(flush_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("rst_fl", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("rst_fl_after", 0, 0, 0, 0, 0);

`ifdef PC_FLOW_CTRL_DBG_HALT_EN
        @(negedge clk);
        dbg_halt_req_i = 1'b1;
        #1;
        chk("halt_enter.halted", 32'(dbg_halted_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(0, (k == 1), (k == 1) ? 32'h500 : 32'h0, 0, 0);
            #1;
            chk_out($sformatf("halt%0d", k), 1, 0, 0, 0, 0);
            chk($sformatf("halt%0d.halted", k), 32'(dbg_halted_o), 32'd1);
        end
        @(negedge clk);
        dbg_halt_req_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        chk_out("halt_last", 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_out("halt_resume", 0, 1, 32'h500, 1, 0);
        chk("halt_resume.halted", 32'(dbg_halted_o), 32'd0);
        repeat (3) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
